// File: rtl/uart_tx_word_sender.sv
// Feeds 16-bit result words to an 8-bit UART transmitter, MSB byte first,
// with a terminator byte after every ROW_LEN words.
module uart_tx_word_sender #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROW_LEN   = 3,
    parameter logic [7:0]  TERM_BYTE = 8'h0A
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     sending,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     row_done
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned COLW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_TERM, WAIT_TERM
    } state_t;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            wr_en, pop, tx_free;

    state_t          state, state_n;
    logic [15:0]     word_reg, word_reg_n;
    logic [COLW-1:0] col_cnt, col_cnt_n;
    logic [7:0]      tx_data_n;
    logic            tx_start_n, row_done_n, sending_n;

    assign s_ready = (fifo_count != CW'(DEPTH));
    assign wr_en   = s_valid && s_ready;
    assign tx_free = !tx_busy && !tx_done;

    // Word FIFO storage; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_reg <= '0;
            col_cnt  <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            row_done <= 1'b0;
            sending  <= 1'b0;
        end else begin
            state    <= state_n;
            word_reg <= word_reg_n;
            col_cnt  <= col_cnt_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            row_done <= row_done_n;
            sending  <= sending_n;
        end
    end

    // Byte sequencing; starts are held off while the transmitter is busy or just finishing
    always_comb begin
        state_n    = state;
        word_reg_n = word_reg;
        col_cnt_n  = col_cnt;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        row_done_n = 1'b0;
        pop        = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        word_reg_n = mem[rd_ptr];
                        state_n    = SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (tx_free) begin
                        tx_data_n  = word_reg[15:8];
                        tx_start_n = 1'b1;
                        state_n    = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_done) state_n = SEND_LO;
                end
                SEND_LO: begin
                    if (tx_free) begin
                        tx_data_n  = word_reg[7:0];
                        tx_start_n = 1'b1;
                        state_n    = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (tx_done) begin
                        if (col_cnt == COLW'(ROW_LEN - 1)) begin
                            col_cnt_n = '0;
                            state_n   = SEND_TERM;
                        end else begin
                            col_cnt_n = col_cnt + 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
                SEND_TERM: begin
                    if (tx_free) begin
                        tx_data_n  = TERM_BYTE;
                        tx_start_n = 1'b1;
                        state_n    = WAIT_TERM;
                    end
                end
                WAIT_TERM: begin
                    if (tx_done) begin
                        row_done_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        sending_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_word_sender.sv
// Bench for uart_tx_word_sender: transmitter model, byte-stream scoreboard,
// directed scenarios plus a randomized run.
module tb_uart_tx_word_sender;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ROW_LEN = 3;
    localparam logic [7:0]  TERM    = 8'h0A;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [15:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready, tx_start, sending, row_done;
    logic [7:0]    tx_data;
    logic          tx_busy, tx_done;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_word_sender #(.DEPTH(DEPTH), .ROW_LEN(ROW_LEN), .TERM_BYTE(TERM)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .sending(sending), .fifo_count(fifo_count), .row_done(row_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy for frame_len cycles, then tx_done for done_len cycles.
    // tx_done is only raised while en=1 so the sender never misses it.
    int frame_len = 3;
    int done_len  = 1;
    bit rand_tx   = 1'b0;
    int tx_phase  = 0;
    int tx_left   = 0;
    int tx_dleft  = 0;

    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                tx_busy = 1'b0; tx_done = 1'b0; tx_phase = 0;
            end else begin
                case (tx_phase)
                    0: if (tx_start) begin
                        if (rand_tx) begin
                            frame_len = $urandom_range(1, 6);
                            done_len  = $urandom_range(1, 2);
                        end
                        tx_busy = 1'b1; tx_left = frame_len; tx_phase = 1;
                    end
                    1: begin
                        if (tx_left > 0) tx_left--;
                        if (tx_left == 0 && en) begin
                            tx_busy = 1'b0; tx_done = 1'b1; tx_dleft = done_len; tx_phase = 2;
                        end
                    end
                    default: begin
                        tx_dleft--;
                        if (tx_dleft == 0) begin
                            tx_done = 1'b0; tx_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Scoreboard: accepted words expand to {is_term, byte} entries in send order
    logic [8:0] expq [$];
    logic [7:0] log_q [$];
    int   rowdone_cnt = 0;
    int   terms_pushed = 0;
    int   wcnt = 0;
    bit   in_frame = 1'b0, cur_term = 1'b0, exp_rd = 1'b0, pv = 1'b0;
    logic p_en, p_busy, p_done, p_start, p_sending;
    logic [7:0] p_data, cur_byte;
    logic [8:0] e;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            wcnt = 0; in_frame = 1'b0; exp_rd = 1'b0; pv = 1'b0;
        end else begin
            if (pv) begin
                chk("row_done", 32'(row_done), 32'(exp_rd));
                if (tx_start) begin
                    chk("start_cond", 32'({p_en, p_busy, p_done, p_start}), 32'h8);
                    chk("start_has_byte", 32'(expq.size() != 0), 32'h1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("byte_order", 32'(tx_data), 32'(e[7:0]));
                        cur_byte = e[7:0];
                        cur_term = e[8];
                    end
                    log_q.push_back(tx_data);
                    in_frame = 1'b1;
                end else if (in_frame) begin
                    chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
                end
                if (in_frame) chk("sending_in_frame", 32'(sending), 32'h1);
                if (!p_en)
                    chk("en_hold", 32'({tx_start, row_done, sending, tx_data}),
                        32'({2'b00, p_sending, p_data}));
            end
            chk("s_ready_vs_count", 32'(s_ready), 32'(fifo_count != CW'(DEPTH)));
            if (fifo_count > CW'(DEPTH)) chk("count_bound", 32'(fifo_count), DEPTH);
            if (row_done) rowdone_cnt++;
            exp_rd = tx_done && en && in_frame && cur_term;
            if (tx_done) in_frame = 1'b0;
            if (s_valid && s_ready) begin
                expq.push_back({1'b0, s_data[15:8]});
                expq.push_back({1'b0, s_data[7:0]});
                wcnt++;
                if (wcnt == ROW_LEN) begin
                    expq.push_back({1'b1, TERM});
                    terms_pushed++;
                    wcnt = 0;
                end
            end
            p_en = en; p_busy = tx_busy; p_done = tx_done; p_start = tx_start;
            p_sending = sending; p_data = tx_data; pv = 1'b1;
        end
    end

    bit saw_full = 1'b0;

    // Call aligned #1 after a posedge; returns #1 after the accepting edge with s_valid still high
    task automatic send_word(input logic [15:0] w);
        bit acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            acc = s_ready;
            if (fifo_count == CW'(DEPTH)) saw_full = 1'b1;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'h1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0 && !sending && fifo_count == '0 && !tx_busy && !tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'h1);
    endtask

    task automatic wait_log(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (log_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_log", 32'(ok), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_sending", 32'(sending), 32'h0);
        chk("rst_row_done", 32'(row_done), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [7:0] exp_row [7] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h0A};

    initial begin
        do_reset();

        // Latency and MSB-first split of a single word
        log_q.delete();
        @(posedge clk); #1;
        send_word(16'hA55A);
        s_valid = 1'b0;
        chk("lat_count_k", 32'(fifo_count), 32'h1);
        @(posedge clk); #1;
        chk("lat_no_start_k1", 32'(tx_start), 32'h0);
        chk("lat_popped_k1", 32'(fifo_count), 32'h0);
        @(posedge clk); #1;
        chk("lat_start_k2", 32'(tx_start), 32'h1);
        chk("lat_data_k2", 32'(tx_data), 32'hA5);
        @(posedge clk); #1;
        chk("lat_start_low_k3", 32'(tx_start), 32'h0);
        wait_idle(200, "t1_drain");
        chk("t1_len", 32'(log_q.size()), 32'h2);
        if (log_q.size() == 2) begin
            chk("t1_b0", 32'(log_q[0]), 32'hA5);
            chk("t1_b1", 32'(log_q[1]), 32'h5A);
        end

        // One full row with terminator
        do_reset();
        log_q.delete(); rowdone_cnt = 0;
        @(posedge clk); #1;
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'h0003);
        s_valid = 1'b0;
        wait_idle(500, "t2_drain");
        chk("t2_len", 32'(log_q.size()), 32'h7);
        if (log_q.size() == 7)
            for (int i = 0; i < 7; i++) chk("t2_byte", 32'(log_q[i]), 32'(exp_row[i]));
        chk("t2_row_done_cnt", 32'(rowdone_cnt), 32'h1);

        // Backpressure against a slow transmitter
        do_reset();
        log_q.delete(); saw_full = 1'b0; frame_len = 20;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send_word(16'hC0D0 + 16'(i));
        s_valid = 1'b0;
        chk("t3_saw_full", 32'(saw_full), 32'h1);
        frame_len = 3;
        wait_idle(2000, "t3_drain");
        chk("t3_len", 32'(log_q.size()), 32'd14);
        if (log_q.size() == 14) begin
            chk("t3_first", 32'(log_q[0]), 32'hC0);
            chk("t3_term1", 32'(log_q[6]), 32'h0A);
            chk("t3_last_lo", 32'(log_q[12]), 32'hD5);
            chk("t3_term2", 32'(log_q[13]), 32'h0A);
        end

        // en dropped while the low byte is in flight
        do_reset();
        log_q.delete(); frame_len = 6;
        @(posedge clk); #1;
        send_word(16'hBEEF);
        s_valid = 1'b0;
        wait_log(2, 200);
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_hold_sending", 32'(sending), 32'h1);
        chk("t4_no_new_start", 32'(log_q.size()), 32'h2);
        en = 1'b1;
        wait_idle(300, "t4_drain");
        if (log_q.size() == 2) chk("t4_lo", 32'(log_q[1]), 32'hEF);

        // Reset while the high byte is in flight, then a fresh word
        log_q.delete();
        @(posedge clk); #1;
        send_word(16'h7E81);
        s_valid = 1'b0;
        wait_log(1, 200);
        repeat (2) @(posedge clk);
        do_reset();
        log_q.delete(); frame_len = 3;
        @(posedge clk); #1;
        send_word(16'h1234);
        s_valid = 1'b0;
        wait_idle(300, "t5_drain");
        chk("t5_len", 32'(log_q.size()), 32'h2);
        if (log_q.size() == 2) begin
            chk("t5_hi", 32'(log_q[0]), 32'h12);
            chk("t5_lo", 32'(log_q[1]), 32'h34);
        end

        // tx_done held for two cycles
        do_reset();
        log_q.delete(); done_len = 2;
        @(posedge clk); #1;
        send_word(16'h3C4D);
        send_word(16'h5E6F);
        s_valid = 1'b0;
        wait_idle(300, "t6_drain");
        chk("t6_len", 32'(log_q.size()), 32'h4);
        if (log_q.size() == 4) chk("t6_b3", 32'(log_q[3]), 32'h6F);
        done_len = 1;

        // Randomized traffic with random en and transmitter timing
        do_reset();
        rowdone_cnt = 0; terms_pushed = 0; rand_tx = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 1500; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; en = 1'b1;
        wait_idle(5000, "rand_drain");
        chk("rand_rows", 32'(rowdone_cnt), 32'(terms_pushed));
        rand_tx = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_word_sender.md
Name: uart_tx_word_sender

Overview:
- Upstream feeder for the 8-bit UART transmitter. Buffers 16-bit matrix-result words in a small FIFO and splits each word into two bytes, MSB first.
- Drives the transmitter's start/data inputs and paces on its busy/done outputs.
- After every ROW_LEN words, appends a row terminator byte so the host sees one matrix row per line.
- Runs on the same clock as the transmitter (baud-rate clock).

Parameters:
- DEPTH, 4, word FIFO depth in entries; power of two, minimum 2.
- ROW_LEN, 3, words per matrix row before the terminator byte is sent; minimum 1.
- TERM_BYTE, 8'h0A, terminator byte sent after each row.

Ports:
- clk  in  1  clock, same (baud-rate) clock as transmitter
- rst  in  1  asynchronous reset, active-high
- en  in  1  FSM advance enable; FIFO writes are not gated by en
- s_data  in  16  result word to send
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept a word (= !full)
- tx_start  out  1  one-cycle registered start pulse to transmitter
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done
- tx_busy  in  1  transmitter busy
- tx_done  in  1  transmitter end-of-frame pulse
- sending  out  1  high whenever FSM is not in IDLE
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- row_done  out  1  one-cycle pulse when the terminator byte's tx_done is seen

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, fifo_count=0, s_ready=1, tx_start=0, tx_data=8'h00, sending=0, row_done=0, col_cnt=0, state=IDLE.
- Reset mid-transmission aborts immediately; the partially sent word is lost and is not resent.
- FIFO write: occurs when s_valid && s_ready.
  - Simultaneous write and pop when full: write is refused (s_ready=0 that cycle).
  - Simultaneous write and pop when empty: pop is not possible; the word is visible next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_TERM, WAIT_TERM.
  - When en=0, the FSM holds state and holds all outputs; tx_start is forced to 0.
- IDLE: if FIFO not empty, latch head word into word_reg, pop, go to SEND_HI.
- SEND_HI / SEND_LO / SEND_TERM (start issue):
  - Issue only when tx_busy==0 && tx_done==0. This guarantees at least one idle cycle after the previous stop bit.
  - On issue: tx_data <= byte (word_reg[15:8] for SEND_HI, word_reg[7:0] for SEND_LO, TERM_BYTE for SEND_TERM), tx_start <= 1 for exactly one cycle, go to the matching WAIT state.
- WAIT_HI: on tx_done, go to SEND_LO.
- WAIT_LO: on tx_done:
  - if col_cnt==ROW_LEN-1: col_cnt <= 0, go to SEND_TERM;
  - else col_cnt <= col_cnt+1, go to IDLE.
- WAIT_TERM: on tx_done, row_done=1 for one cycle, go to IDLE.
- tx_done seen in a non-WAIT state is ignored.
- Latency, word written into an empty FIFO at edge k with transmitter idle:
  - popped at edge k+1;
  - tx_start high after edge k+2, low after edge k+3.
- Per-word byte count: 2 bytes, plus 1 terminator byte on each ROW_LEN-th word.

Test Plan:
- Reset, then write 16'hA55A with transmitter model idle -> tx_start pulses at cycle 2 with tx_data=8'hA5; after tx_done, tx_data=8'h5A pulse; fifo_count returns to 0; sending drops after second tx_done.
- ROW_LEN=3, write 16'h0001, 16'h0002, 16'h0003 -> transmitted bytes 00 01 00 02 00 03 0A; row_done pulses once, after the 0A frame's tx_done.
- Hold s_valid=1 for 6 distinct words with DEPTH=4 while the transmitter is slow -> s_ready falls when fifo_count=4; no word is lost or duplicated; output byte order matches input order.
- Drop en=0 while in WAIT_LO with tx_done arriving -> FSM holds state, no new tx_start is issued; on en=1, resumes in the correct order. Sending tx_done during en=0 is dropped by design, so the bench must deliver tx_done while en=1.
- Assert rst for 1 cycle during WAIT_HI -> all outputs take reset values asynchronously; a new word written after reset is sent MSB first from scratch.
- tx_done held high the cycle after the SEND_LO entry -> no tx_start is issued until tx_done=0 and tx_busy=0.
